// File: rtl/serial_disp_rx_if.sv
// ---------------------------------------------------------------------------
// serial_disp_rx_if
//
// Purpose:
//   Bundles the four lines of the board's serial display/LED shift-out
//   protocol so the serializer side and the loopback receiver share one
//   definition of the bus.
//
// Signals:
//   s_clk   serial shift clock, data is taken on its rising edge
//   s_din   serial data
//   s_clrn  active-low clear of the shift chain
//   s_pen   latch enable, rising edge moves the chain to the outputs
//
// Modports:
//   master  drives the bus (serializer or testbench)
//   slave   observes the bus (serial_disp_rx)
// ---------------------------------------------------------------------------
interface serial_disp_rx_if;
    logic s_clk;
    logic s_din;
    logic s_clrn;
    logic s_pen;

    modport master (
        output s_clk,
        output s_din,
        output s_clrn,
        output s_pen
    );

    modport slave (
        input s_clk,
        input s_din,
        input s_clrn,
        input s_pen
    );
endinterface

// File: rtl/serial_disp_rx.sv
// ---------------------------------------------------------------------------
// serial_disp_rx
//
// Purpose:
//   Loopback monitor for the serial display/LED shift-out stream. Rebuilds
//   the parallel frame that the on-board shift-register chain would hold,
//   so the design can compare what it shifted out with what it meant to
//   show. Reports good frames and frames latched with the wrong length.
//   All serial inputs are asynchronous to clk.
//
// Parameters:
//   FRAME_BITS  bits per frame (64 for seven-segment, 16 for LEDs)
//   CNT_W       bit counter width, 2**CNT_W must exceed FRAME_BITS+1
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   ser          serial bus (slave modport): s_clk, s_din, s_clrn, s_pen
//   frame_data   last good latched frame, first bit sent in the MSB
//   frame_valid  one-cycle pulse when frame_data updates
//   frame_err    one-cycle pulse when a latch sees the wrong bit count
//   bit_cnt      bits shifted since last latch/clear, saturating
//   frame_total  number of good frames, wrapping
//
// Build option:
//   SERIAL_DISP_RX_GLITCH_FILTER_EN  when defined, s_clk and s_pen levels
//   must be stable for 3 synchronized samples before being accepted, and
//   s_din is delayed to match (2 extra clk of latency).
// ---------------------------------------------------------------------------
module serial_disp_rx #(
    parameter int FRAME_BITS = 64,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_disp_rx_if.slave       ser,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic [15:0]           frame_total
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    // Two-flop synchronizers, index 1 is the usable synchronized level.
    logic [1:0] clk_sync;
    logic [1:0] din_sync;
    logic [1:0] clrn_sync;
    logic [1:0] pen_sync;

    logic shift_evt;
    logic pen_evt;
    logic din_bit;
    logic clr_act;

    logic [FRAME_BITS-1:0] shift_reg;
    logic                  latch_pend;

    // Clear and PEN synchronizers come out of reset at their idle-high
    // level so a PEN pin held low does not look like an edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b00;
            din_sync  <= 2'b00;
            clrn_sync <= 2'b11;
            pen_sync  <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ser.s_clk};
            din_sync  <= {din_sync[0], ser.s_din};
            clrn_sync <= {clrn_sync[0], ser.s_clrn};
            pen_sync  <= {pen_sync[0], ser.s_pen};
        end
    end

`ifdef SERIAL_DISP_RX_GLITCH_FILTER_EN
    // Two more samples of each synchronized level; together with the
    // current synchronized value they form a 3-sample stability window.
    // The accepted level only moves when all three samples agree, and an
    // edge is reported in the cycle the window first agrees on a new
    // level. s_din goes through the same two stages to stay aligned.
    logic [1:0] clk_hist;
    logic [1:0] pen_hist;
    logic [1:0] din_hist;
    logic       clk_lvl;
    logic       pen_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_hist <= 2'b00;
            pen_hist <= 2'b11;
            din_hist <= 2'b00;
            clk_lvl  <= 1'b0;
            pen_lvl  <= 1'b1;
        end else begin
            clk_hist <= {clk_hist[0], clk_sync[1]};
            pen_hist <= {pen_hist[0], pen_sync[1]};
            din_hist <= {din_hist[0], din_sync[1]};
            if (clk_sync[1] && (&clk_hist)) begin
                clk_lvl <= 1'b1;
            end else if (!clk_sync[1] && !(|clk_hist)) begin
                clk_lvl <= 1'b0;
            end
            if (pen_sync[1] && (&pen_hist)) begin
                pen_lvl <= 1'b1;
            end else if (!pen_sync[1] && !(|pen_hist)) begin
                pen_lvl <= 1'b0;
            end
        end
    end

    assign shift_evt = clk_sync[1] & (&clk_hist) & ~clk_lvl;
    assign pen_evt   = pen_sync[1] & (&pen_hist) & ~pen_lvl;
    assign din_bit   = din_hist[1];
`else
    // Previous synchronized level for rising-edge detection. PEN history
    // starts high to match its synchronizer reset value.
    logic clk_prev;
    logic pen_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev <= 1'b0;
            pen_prev <= 1'b1;
        end else begin
            clk_prev <= clk_sync[1];
            pen_prev <= pen_sync[1];
        end
    end

    assign shift_evt = clk_sync[1] & ~clk_prev;
    assign pen_evt   = pen_sync[1] & ~pen_prev;
    assign din_bit   = din_sync[1];
`endif

    assign clr_act = ~clrn_sync[1];

    // Shift chain, bit counter and latch. A PEN edge is registered into
    // latch_pend first, so a shift detected in the same cycle as the PEN
    // edge has already landed in shift_reg/bit_cnt when the latch decision
    // is made. An active clear forces the latch to see a count of zero.
    // A shift arriving exactly on the latch cycle starts the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            latch_pend  <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_total <= 16'd0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            latch_pend  <= pen_evt;

            if (clr_act) begin
                shift_reg <= '0;
            end else if (shift_evt) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], din_bit};
            end

            if (clr_act) begin
                bit_cnt <= '0;
            end else if (latch_pend) begin
                bit_cnt <= shift_evt ? CNT_W'(1) : '0;
            end else if (shift_evt && (bit_cnt != CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (latch_pend) begin
                if (!clr_act && (bit_cnt == CNT_FULL)) begin
                    frame_data  <= shift_reg;
                    frame_valid <= 1'b1;
                    frame_total <= frame_total + 16'd1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/serial_disp_rx.md
Name: serial_disp_rx

Overview:
- Receiving end of the board's serial display/LED shift-out protocol: clock, data, active-low clear, and latch-enable (PEN).
- Rebuilds the parallel frame the on-board shift-register chain would hold, and reports frame completion and frame-length errors.
- Used as a loopback monitor on the seven-segment stream (64 bits) or the LED stream (16 bits). The design can then check what it shifted out against what it meant to show.
- Sits beside the display/LED serializers. All four inputs are asynchronous to clk.

Parameters:
- FRAME_BITS, 64: bits per frame. Set to 16 for the LED stream.
- CNT_W, 8: width of the internal bit counter. Must satisfy 2^CNT_W > FRAME_BITS+1.

Ports:
- clk  input  1  system clock (clk_100mhz domain).
- rst  input  1  synchronous, active-high reset.
- s_clk  input  1  serial shift clock. Data is shifted on its rising edge.
- s_din  input  1  serial data.
- s_clrn  input  1  active-low clear of the shift chain.
- s_pen  input  1  latch enable. Its rising edge transfers the shift chain to the output.
- frame_data  output  FRAME_BITS  last good latched frame.
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- frame_err  output  1  one-cycle pulse on a latch with the wrong bit count.
- bit_cnt  output  CNT_W  bits shifted since the last latch or clear, saturating.
- frame_total  output  16  count of good frames, wraps at 16'hFFFF to 0.

Behaviour:
- Reset: synchronous, active-high. All registers clear on the rising clk edge where rst=1: shift_reg, frame_data, bit_cnt, frame_total, edge history. frame_valid and frame_err are 0. Synchronizer flops reset to s_clk=0, s_din=0, s_clrn=1, s_pen=1, so a stuck-low PEN does not produce a false edge after reset. Reset mid-frame discards any partial frame.
- Input sync: each input passes through a 2-flop synchronizer. A third flop holds the previous value for edge detection.
  - Rising edge of s_clk: sync2=1 and prev=0. The shift then occurs on the 3rd clk edge after the pin change is first sampled.
  - s_din uses the same pipeline depth, so it stays aligned with s_clk.
- Source timing requirements: s_clk high ≥3 clk periods and low ≥3 clk periods. s_din stable from ≥2 clk before to ≥2 clk after each s_clk rise.
- Shift: on a detected s_clk rising edge, shift_reg <= {shift_reg[FRAME_BITS-2:0], din}. The first bit sent ends in frame_data[FRAME_BITS-1].
  - bit_cnt increments and saturates at FRAME_BITS+1. Extra bits keep shifting, so the oldest bits are lost.
- Clear: while synchronized s_clrn=0, shift_reg and bit_cnt are held at 0. Clear beats a coincident shift.
- Latch: on a detected s_pen rising edge, with the result registered 1 cycle later:
  - If bit_cnt == FRAME_BITS: frame_data <= shift_reg, frame_valid=1, frame_total+1.
  - Otherwise: frame_err=1 and frame_data is unchanged.
  - In both cases bit_cnt returns to 0. shift_reg is kept, matching a real chain.
- Shift and PEN edges in the same cycle: the shift is applied first, and the latch sees the new shift_reg and the incremented bit_cnt.
- Clear and PEN edges in the same cycle: the latch is evaluated with bit_cnt=0. This gives frame_err unless FRAME_BITS==0, which is not allowed.
- frame_valid and frame_err never assert together, and never for more than one cycle per PEN edge.
- End-to-end latency: 4 clk from first sampling of the s_pen rise to frame_valid=1.

Optional Feature:
- Macro: SERIAL_DISP_RX_GLITCH_FILTER_EN.
- Defined:
  - A synchronized s_clk or s_pen level is accepted only after it has been stable for 3 consecutive clk samples. Shorter pulses are ignored and never counted.
  - s_din is delayed by the same 2 extra cycles, so latency grows by 2 clk (shift at the 5th edge, frame_valid at 6 clk).
  - The minimum high/low time on s_clk becomes 5 clk periods.
- Undefined: no filter, timing as stated above.

Test Plan:
- Reset, send 64 bits of 64'hF0E1_D2C3_B4A5_9687 MSB first (s_clk 8 clk high/8 low), then pulse s_pen -> frame_data=64'hF0E1D2C3B4A59687, one frame_valid pulse 4 clk after the PEN rise, frame_total=1, bit_cnt=0.
- Send 63 bits, then PEN -> frame_err pulse, frame_data keeps its previous value, frame_total unchanged. Then send 66 bits of 0x..AA pattern and PEN -> frame_err, bit_cnt read 65 just before the latch.
- Shift 40 bits, hold s_clrn low for 4 clk, send a full 64-bit 64'h0000_0000_0000_0001 frame, PEN -> frame_valid, frame_data=1.
- Align the last s_clk rise and the s_pen rise on the same clk sample -> the last bit is included, frame_valid asserts (no error).
- Assert rst for 1 cycle after 30 bits, then send 64 bits of all 1s plus PEN -> frame_data=all 1s, frame_total=1.
- With SERIAL_DISP_RX_GLITCH_FILTER_EN: inject a 2-clk s_clk high glitch during a frame -> bit_cnt unchanged and the frame latches correctly. Without the macro, the same glitch (with 2-clk filter timing violated) produces frame_err.
